ax_level_sequencer: RTL

//  Owns the core-wide approximation level (axLevel) consumed by BranchDecider, DCache and CSR_Unit.

---
 rtl/ax_level_sequencer_if.sv | 30 +++
 rtl/ax_level_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/ax_level_sequencer_if.sv
// Level-change request/response bundle between the requesters, the pipeline
// and the approximation-level sequencer.
interface ax_level_sequencer_if #(
    parameter int AX_LEVEL_WIDTH = 3
);
    logic                      csrReqValid;
    logic [AX_LEVEL_WIDTH-1:0] csrReqLevel;
    logic                      csrReqReady;
    logic                      extReqValid;
    logic [AX_LEVEL_WIDTH-1:0] extReqLevel;
    logic                      extReqReady;
    logic                      pipelineEmpty;
    logic                      stallFetch;
    logic [AX_LEVEL_WIDTH-1:0] axLevel;
    logic                      levelChanging;
    logic                      changeDone;
    logic                      timeoutErr;

    modport slave (
        input  csrReqValid, csrReqLevel, extReqValid, extReqLevel, pipelineEmpty,
        output csrReqReady, extReqReady, stallFetch, axLevel, levelChanging,
               changeDone, timeoutErr
    );

    modport master (
        output csrReqValid, csrReqLevel, extReqValid, extReqLevel, pipelineEmpty,
        input  csrReqReady, extReqReady, stallFetch, axLevel, levelChanging,
               changeDone, timeoutErr
    );
endinterface

// File: rtl/ax_level_sequencer.sv
// Owns the core-wide approximation level: arbitrates CSR/external change requests,
// drains the pipeline under a fetch stall, applies the level, then settles.
module ax_level_sequencer #(
    parameter int AX_LEVEL_WIDTH   = 3,
    parameter int DEFAULT_AX_LEVEL = 0,
    parameter int MAX_AX_LEVEL     = 5,
    parameter int DRAIN_TIMEOUT    = 64,
    parameter int SETTLE_CYCLES    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    ax_level_sequencer_if.slave  bus
);
    localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [AX_LEVEL_WIDTH-1:0] MAX_LVL   = AX_LEVEL_WIDTH'(MAX_AX_LEVEL);
    localparam logic [AX_LEVEL_WIDTH-1:0] RESET_LVL = AX_LEVEL_WIDTH'(DEFAULT_AX_LEVEL);
    localparam logic [DW-1:0] DRAIN_LAST  = DW'(DRAIN_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, APPLY, SETTLE} state_t;

    state_t                    state, stateNext;
    logic [DW-1:0]             drainCnt, drainCntNext;
    logic [SW-1:0]             settleCnt, settleCntNext;
    logic [AX_LEVEL_WIDTH-1:0] levelQ, levelNext;
    logic [AX_LEVEL_WIDTH-1:0] pendingLevel, pendingNext;
    logic                      doneQ, doneNext;
    logic                      timeoutQ, timeoutNext;
    logic                      reqValid;
    logic [AX_LEVEL_WIDTH-1:0] reqLevel, clampedLevel;

    // CSR wins whenever it is valid; the external port only sees ready otherwise.
    always_comb begin
        reqValid     = bus.csrReqValid || bus.extReqValid;
        reqLevel     = bus.csrReqValid ? bus.csrReqLevel : bus.extReqLevel;
        clampedLevel = (reqLevel > MAX_LVL) ? MAX_LVL : reqLevel;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext     = state;
        drainCntNext  = drainCnt;
        settleCntNext = settleCnt;
        levelNext     = levelQ;
        pendingNext   = pendingLevel;
        doneNext      = 1'b0;
        timeoutNext   = 1'b0;
        unique case (state)
            IDLE: begin
                if (reqValid) begin
                    if (clampedLevel == levelQ) begin
                        doneNext = 1'b1;
                    end else begin
                        stateNext    = DRAIN;
                        drainCntNext = '0;
                        pendingNext  = clampedLevel;
                    end
                end
            end
            DRAIN: begin
                // A drained pipeline on the final allowed cycle still applies.
                if (bus.pipelineEmpty) begin
                    stateNext = APPLY;
                end else if (drainCnt == DRAIN_LAST) begin
                    stateNext   = IDLE;
                    timeoutNext = 1'b1;
                end else begin
                    drainCntNext = drainCnt + 1'b1;
                end
            end
            APPLY: begin
                levelNext     = pendingLevel;
                stateNext     = SETTLE;
                settleCntNext = '0;
            end
            SETTLE: begin
                if (settleCnt == SETTLE_LAST) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end else begin
                    settleCntNext = settleCnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drainCnt     <= '0;
            settleCnt    <= '0;
            levelQ       <= RESET_LVL;
            pendingLevel <= RESET_LVL;
            doneQ        <= 1'b0;
            timeoutQ     <= 1'b0;
        end else begin
            drainCnt     <= drainCntNext;
            settleCnt    <= settleCntNext;
            levelQ       <= levelNext;
            pendingLevel <= pendingNext;
            doneQ        <= doneNext;
            timeoutQ     <= timeoutNext;
        end
    end

    // Readies are held low while reset is asserted, not just while idle.
    assign bus.csrReqReady   = (state == IDLE) && rst;
    assign bus.extReqReady   = (state == IDLE) && rst && !bus.csrReqValid;
    assign bus.stallFetch    = (state != IDLE);
    assign bus.levelChanging = (state != IDLE);
    assign bus.axLevel       = levelQ;
    assign bus.changeDone    = doneQ;
    assign bus.timeoutErr    = timeoutQ;
endmodule
